// File: rtl/sound_event_scheduler_pkg.sv
// Shared types and constants for the sound event scheduler: FSM states,
// source indices, tone frequencies and direction encodings.
package sound_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } sched_state_t;

   localparam int NUM_SRC = 4;

   // Lower index means higher priority.
   localparam logic [1:0] SRC_BAD  = 2'd0;
   localparam logic [1:0] SRC_GOOD = 2'd1;
   localparam logic [1:0] SRC_BTN  = 2'd2;
   localparam logic [1:0] SRC_DIR  = 2'd3;

   localparam logic [8:0] FREQ_BAD   = 9'd110;
   localparam logic [8:0] FREQ_GOOD  = 9'd440;
   localparam logic [8:0] FREQ_BTN   = 9'd330;
   localparam logic [8:0] FREQ_UP    = 9'd262;
   localparam logic [8:0] FREQ_DOWN  = 9'd294;
   localparam logic [8:0] FREQ_LEFT  = 9'd349;
   localparam logic [8:0] FREQ_RIGHT = 9'd392;

   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_DOWN  = 4'b0010;
   localparam logic [3:0] DIR_LEFT  = 4'b0100;
   localparam logic [3:0] DIR_RIGHT = 4'b1000;

   function automatic logic is_one_hot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [8:0] dir_freq(input logic [3:0] dir);
      case (dir)
         DIR_UP:    return FREQ_UP;
         DIR_DOWN:  return FREQ_DOWN;
         DIR_LEFT:  return FREQ_LEFT;
         DIR_RIGHT: return FREQ_RIGHT;
         default:   return 9'd0;
      endcase
   endfunction

   function automatic logic [1:0] highest_pending(input logic [NUM_SRC-1:0] pend);
      logic [1:0] idx;
      idx = SRC_DIR;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pend[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sound_event_scheduler_edge_detect.sv
// Input history for the sound scheduler: rising-edge pulses for the level
// requests and a change-detect on one-hot direction values.
module sound_edge_detect (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] req_level,
   input  logic [3:0] direction,
   output logic [2:0] req_event,
   output logic       dir_event,
   output logic [3:0] dir_value
);
   import sound_pkg::*;

   logic [2:0] req_prev_reg;
   logic [3:0] dir_prev_reg;

   // History tracks every sample, including invalid directions, so a
   // return to a previously held one-hot value still counts as a change.
   always_ff @(posedge clk) begin
      if (rst) begin
         req_prev_reg <= '0;
         dir_prev_reg <= '0;
      end else begin
         req_prev_reg <= req_level;
         dir_prev_reg <= direction;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_req
         assign req_event[gi] = req_level[gi] & ~req_prev_reg[gi];
      end
   endgenerate

   assign dir_event = is_one_hot(direction) && (direction != dir_prev_reg);
   assign dir_value = direction;

endmodule

// File: rtl/sound_event_scheduler.sv
// Fixed-priority arbiter driving one timed tone plus silent gap per grant.
// Optional SOUND_SCHED_MUTE_EN adds mute_i, which flushes and silences.
module sound_event_scheduler #(
   parameter int              FREQ_W   = 9,
   parameter int              DUR_W    = 20,
   parameter logic [DUR_W-1:0] TONE_DUR = 20'd600000,
   parameter logic [DUR_W-1:0] GAP_DUR  = 20'd60000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              goodColl_i,
   input  logic              badColl_i,
   input  logic              button_i,
   input  logic [3:0]        direction_i,
`ifdef SOUND_SCHED_MUTE_EN
   input  logic              mute_i,
`endif
   output logic [FREQ_W-1:0] freq_o,
   output logic              playSound_o,
   output logic              busy_o
);
   import sound_pkg::*;

   sched_state_t        state_reg, state_next;
   logic [DUR_W-1:0]    counter_reg, counter_next;
   logic [FREQ_W-1:0]   freq_reg, freq_next;
   logic                play_reg, play_next;
   logic [1:0]          cur_src_reg, cur_src_next;
   logic [NUM_SRC-1:0]  pending_reg, pending_next;
   logic [3:0]          dir_latch_reg, dir_latch_next;

   logic [2:0]          req_level;
   logic [2:0]          req_event;
   logic                dir_event;
   logic [3:0]          dir_value;
   logic [NUM_SRC-1:0]  event_vec;
   logic [NUM_SRC-1:0]  grant_mask;
   logic [1:0]          grant_src;
   logic                mute_active;

`ifdef SOUND_SCHED_MUTE_EN
   assign mute_active = mute_i;
`else
   assign mute_active = 1'b0;
`endif

   assign req_level[SRC_BAD]  = badColl_i;
   assign req_level[SRC_GOOD] = goodColl_i;
   assign req_level[SRC_BTN]  = button_i;

   sound_edge_detect u_edge (
      .clk       (clk),
      .rst       (rst),
      .req_level (req_level),
      .direction (direction_i),
      .req_event (req_event),
      .dir_event (dir_event),
      .dir_value (dir_value)
   );

   assign event_vec = {dir_event, req_event};

   function automatic logic [FREQ_W-1:0] src_freq(input logic [1:0] src, input logic [3:0] dir);
      case (src)
         SRC_BAD:  return FREQ_W'(FREQ_BAD);
         SRC_GOOD: return FREQ_W'(FREQ_GOOD);
         SRC_BTN:  return FREQ_W'(FREQ_BTN);
         default:  return FREQ_W'(dir_freq(dir));
      endcase
   endfunction

   always_comb begin
      state_next     = state_reg;
      counter_next   = counter_reg;
      freq_next      = freq_reg;
      play_next      = play_reg;
      cur_src_next   = cur_src_reg;
      grant_mask     = '0;
      grant_src      = highest_pending(pending_reg);

      case (state_reg)
         IDLE: begin
            if (|pending_reg) begin
               grant_mask[grant_src] = 1'b1;
               cur_src_next = grant_src;
               freq_next    = src_freq(grant_src, dir_latch_reg);
               play_next    = 1'b1;
               counter_next = TONE_DUR - DUR_W'(1);
               state_next   = PLAY;
            end
         end
         PLAY: begin
            // A pending bad collision cuts any other tone short; the
            // interrupted source is not re-queued.
            if (pending_reg[SRC_BAD] && (cur_src_reg != SRC_BAD)) begin
               grant_mask[SRC_BAD] = 1'b1;
               cur_src_next = SRC_BAD;
               freq_next    = FREQ_W'(FREQ_BAD);
               counter_next = TONE_DUR - DUR_W'(1);
            end else if (counter_reg == '0) begin
               play_next    = 1'b0;
               counter_next = GAP_DUR - DUR_W'(1);
               state_next   = GAP;
            end else begin
               counter_next = counter_reg - DUR_W'(1);
            end
         end
         GAP: begin
            if (counter_reg == '0) begin
               state_next = IDLE;
            end else begin
               counter_next = counter_reg - DUR_W'(1);
            end
         end
         default: begin
            state_next = IDLE;
            play_next  = 1'b0;
         end
      endcase

      // Setting beats clearing so an event on its own grant edge survives.
      pending_next   = (pending_reg & ~grant_mask) | event_vec;
      dir_latch_next = dir_event ? dir_value : dir_latch_reg;

      if (mute_active) begin
         state_next   = IDLE;
         play_next    = 1'b0;
         counter_next = '0;
         freq_next    = freq_reg;
         cur_src_next = cur_src_reg;
         pending_next = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         counter_reg   <= '0;
         freq_reg      <= '0;
         play_reg      <= 1'b0;
         cur_src_reg   <= SRC_BAD;
         pending_reg   <= '0;
         dir_latch_reg <= '0;
      end else begin
         state_reg     <= state_next;
         counter_reg   <= counter_next;
         freq_reg      <= freq_next;
         play_reg      <= play_next;
         cur_src_reg   <= cur_src_next;
         pending_reg   <= pending_next;
         dir_latch_reg <= dir_latch_next;
      end
   end

   assign freq_o      = freq_reg;
   assign playSound_o = play_reg;
   assign busy_o      = (state_reg != IDLE);

endmodule
